// File: rtl/gcd_array.sv
// Array of subtractive-Euclid GCD engines behind one val/rdy operand port and one
// val/rdy result port. Requests are dispatched round-robin and retire in issue order.
module gcd_array #(
    parameter int unsigned W         = 16,
    parameter int unsigned NUM_UNITS = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [W-1:0]                     operands_bits_A,
    input  logic [W-1:0]                     operands_bits_B,
    input  logic                             operands_val,
    output logic                             operands_rdy,
    output logic [W-1:0]                     result_bits_data,
    output logic                             result_val,
    input  logic                             result_rdy,
    output logic [$clog2(NUM_UNITS+1)-1:0]   outstanding
);

    localparam int unsigned PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned OW = $clog2(NUM_UNITS + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(NUM_UNITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } eng_state_e;

    eng_state_e     state_q [NUM_UNITS];
    eng_state_e     state_d [NUM_UNITS];
    logic [W-1:0]   a_q     [NUM_UNITS];
    logic [W-1:0]   a_d     [NUM_UNITS];
    logic [W-1:0]   b_q     [NUM_UNITS];
    logic [W-1:0]   b_d     [NUM_UNITS];

    logic [PW-1:0]  disp_ptr_q, disp_ptr_d;
    logic [PW-1:0]  ret_ptr_q, ret_ptr_d;
    logic [OW-1:0]  cnt_q, cnt_d;
    logic           rdy_q, rdy_d;
    logic           val_q, val_d;
    logic [W-1:0]   data_q, data_d;

    logic           accept;
    logic           retire;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // Engine FSMs, pointers, occupancy and the next value of every registered output.
    always_comb begin
        accept     = operands_val & rdy_q;
        retire     = val_q & result_rdy;
        disp_ptr_d = disp_ptr_q;
        ret_ptr_d  = ret_ptr_q;
        cnt_d      = cnt_q;

        for (int i = 0; i < NUM_UNITS; i++) begin
            state_d[i] = state_q[i];
            a_d[i]     = a_q[i];
            b_d[i]     = b_q[i];
            case (state_q[i])
                S_IDLE: begin
                    if (accept && (disp_ptr_q == PW'(i))) begin
                        a_d[i]     = operands_bits_A;
                        b_d[i]     = operands_bits_B;
                        state_d[i] = S_CALC;
                    end
                end
                S_CALC: begin
                    if (a_q[i] < b_q[i]) begin
                        a_d[i] = b_q[i];
                        b_d[i] = a_q[i];
                    end else if (b_q[i] != '0) begin
                        a_d[i] = a_q[i] - b_q[i];
                    end else begin
                        state_d[i] = S_DONE;
                    end
                end
                S_DONE: begin
                    if (retire && (ret_ptr_q == PW'(i))) begin
                        state_d[i] = S_IDLE;
                    end
                end
                default: state_d[i] = S_IDLE;
            endcase
        end

        if (accept) begin
            disp_ptr_d = ptr_inc(disp_ptr_q);
        end
        if (retire) begin
            ret_ptr_d = ptr_inc(ret_ptr_q);
        end

        case ({accept, retire})
            2'b10:   cnt_d = cnt_q + OW'(1);
            2'b01:   cnt_d = cnt_q - OW'(1);
            default: cnt_d = cnt_q;
        endcase

        // Outputs are registered copies of what the decode of next state will show.
        rdy_d  = (state_d[disp_ptr_d] == S_IDLE);
        val_d  = (state_d[ret_ptr_d] == S_DONE);
        data_d = val_d ? a_d[ret_ptr_d] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= S_IDLE;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
            end
            disp_ptr_q <= '0;
            ret_ptr_q  <= '0;
            cnt_q      <= '0;
            rdy_q      <= 1'b1;
            val_q      <= 1'b0;
            data_q     <= '0;
        end else begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                state_q[i] <= state_d[i];
                a_q[i]     <= a_d[i];
                b_q[i]     <= b_d[i];
            end
            disp_ptr_q <= disp_ptr_d;
            ret_ptr_q  <= ret_ptr_d;
            cnt_q      <= cnt_d;
            rdy_q      <= rdy_d;
            val_q      <= val_d;
            data_q     <= data_d;
        end
    end

    assign operands_rdy     = rdy_q;
    assign result_val       = val_q;
    assign result_bits_data = data_q;
    assign outstanding      = cnt_q;

endmodule

// File: tb/tb_gcd_array.sv
// Directed and randomized bench for gcd_array with an in-order result scoreboard.
module tb_gcd_array;

    localparam int unsigned W  = 16;
    localparam int unsigned NU = 4;
    localparam int unsigned OW = $clog2(NU + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic          op_val = 1'b0;
    logic          op_rdy;
    logic [W-1:0]  res_data;
    logic          res_val;
    logic          res_rdy = 1'b1;
    logic [OW-1:0] outstanding;

    int checks = 0;
    int errors = 0;
    bit rand_rdy = 1'b0;
    logic [W-1:0] exp_q [$];

    gcd_array #(.W(W), .NUM_UNITS(NU)) dut (
        .clk              (clk),
        .reset            (reset),
        .operands_bits_A  (op_a),
        .operands_bits_B  (op_b),
        .operands_val     (op_val),
        .operands_rdy     (op_rdy),
        .result_bits_data (res_data),
        .result_val       (res_val),
        .result_rdy       (res_rdy),
        .outstanding      (outstanding)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] a = x;
        logic [W-1:0] b = y;
        logic [W-1:0] t;
        while (b != '0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: push on accept, pop and compare on retire.
    always @(negedge clk) begin
        if (!reset) begin
            if (op_val && op_rdy) begin
                exp_q.push_back(gcd_ref(op_a, op_b));
            end
            if (res_val && res_rdy) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $error("FAIL retire_unexpected: observed %0d expected no result", res_data);
                end else begin
                    logic [W-1:0] e;
                    e = exp_q.pop_front();
                    checks++;
                    assert (res_data === e) else begin
                        errors++;
                        $error("FAIL result: observed %0d expected %0d", res_data, e);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) res_rdy = 1'($urandom_range(0, 1));
    endtask

    // Drives one pair and returns 1 time unit after the accepting edge, leaving op_val high.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc = 1'b0;
        op_a   = a;
        op_b   = b;
        op_val = 1'b1;
        for (int i = 0; i < 2000 && !acc; i++) begin
            @(negedge clk);
            acc = op_rdy;
            step();
        end
        chk("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle(input int max_cycles);
        bit done = 1'b0;
        op_val = 1'b0;
        for (int i = 0; i < max_cycles && !done; i++) begin
            step();
            done = (outstanding == '0) && (exp_q.size() == 0) && !res_val;
        end
        chk("idle_timeout", 32'(done), 32'd1);
    endtask

    logic [W-1:0] dir_a [8] = '{16'd27, 16'd21, 16'd25, 16'd19, 16'd40, 16'd250, 16'd5, 16'd0};
    logic [W-1:0] dir_b [8] = '{16'd15, 16'd49, 16'd30, 16'd27, 16'd40, 16'd190, 16'd250, 16'd0};
    logic [W-1:0] dir_r [8] = '{16'd3, 16'd7, 16'd5, 16'd1, 16'd40, 16'd10, 16'd5, 16'd0};

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_rdy", 32'(op_rdy), 32'd1);
        chk("reset_val", 32'(res_val), 32'd0);
        chk("reset_data", 32'(res_data), 32'd0);
        chk("reset_outstanding", 32'(outstanding), 32'd0);

        // Directed vectors, one at a time; also cross-check the reference model.
        for (int i = 0; i < 8; i++) begin
            chk("ref_model", 32'(gcd_ref(dir_a[i], dir_b[i])), 32'(dir_r[i]));
            send(dir_a[i], dir_b[i]);
            wait_idle(600);
            chk("dir_outstanding", 32'(outstanding), 32'd0);
        end

        // Ordering: the long job must be presented before the short one.
        send(16'd250, 16'd1);
        send(16'd40, 16'd40);
        op_val = 1'b0;
        repeat (5) step();
        chk("order_hold_val", 32'(res_val), 32'd0);
        chk("order_outstanding", 32'(outstanding), 32'd2);
        wait_idle(600);

        // Full array under backpressure.
        res_rdy = 1'b0;
        send(16'd27, 16'd15);
        send(16'd21, 16'd49);
        send(16'd25, 16'd30);
        send(16'd19, 16'd27);
        op_val = 1'b0;
        chk("full_rdy", 32'(op_rdy), 32'd0);
        chk("full_outstanding", 32'(outstanding), 32'd4);
        repeat (40) step();
        for (int i = 0; i < 22; i++) begin
            step();
            chk("hold_val", 32'(res_val), 32'd1);
            chk("hold_data", 32'(res_data), 32'd3);
        end
        res_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("drain_val", 32'(res_val), 32'd1);
            step();
            if (i == 0) begin
                chk("rdy_after_retire", 32'(op_rdy), 32'd1);
                chk("drain_outstanding", 32'(outstanding), 32'd3);
            end
        end
        chk("drained_outstanding", 32'(outstanding), 32'd0);
        wait_idle(50);

        // Random stream with random result backpressure; pointers wrap several times.
        rand_rdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send(W'($urandom_range(0, 300)), W'($urandom_range(0, 300)));
        end
        wait_idle(6000);
        rand_rdy = 1'b0;
        res_rdy  = 1'b1;
        step();

        // Reset in the middle of work discards everything in flight.
        send(16'd250, 16'd1);
        send(16'd250, 16'd190);
        op_val = 1'b0;
        repeat (18) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("midreset_val", 32'(res_val), 32'd0);
        chk("midreset_outstanding", 32'(outstanding), 32'd0);
        chk("midreset_rdy", 32'(op_rdy), 32'd1);
        repeat (5) step();
        chk("midreset_no_stale", 32'(res_val), 32'd0);
        send(16'd21, 16'd49);
        wait_idle(600);

        // Edge operands and minimum latency.
        send(16'd0, 16'd65535);
        wait_idle(600);
        send(16'd65535, 16'd0);
        wait_idle(600);
        send(16'd0, 16'd0);
        op_val = 1'b0;
        chk("lat_accept_cycle", 32'(res_val), 32'd0);
        step();
        chk("lat_next_cycle", 32'(res_val), 32'd1);
        chk("lat_data", 32'(res_data), 32'd0);
        wait_idle(50);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
